// File: rtl/matrix_calc_pkg.sv
// matrix_calc_pkg: shared definitions for the UART transmit queue.
//   TXQ_DEPTH   default FIFO depth
//   txq_state_t drain-FSM states
//   SRC_DISP / SRC_MSG arbiter source identifiers
package matrix_calc_pkg;

  localparam int TXQ_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_RISE,
    WAIT_FALL
  } txq_state_t;

  localparam logic SRC_DISP = 1'b0;
  localparam logic SRC_MSG  = 1'b1;

endpackage

// File: rtl/txq_fifo.sv
// txq_fifo: single-clock DEPTHx8 FIFO with synchronous flush.
// Ports:
//   clk_100m, rst_n   clock, asynchronous active-low reset
//   clear             synchronous flush (wins over push/pop)
//   push, push_data   write request and byte (ignored while full)
//   pop               read request (ignored while empty)
//   head              byte at the read pointer (combinational)
//   level             occupancy 0..DEPTH
//   full, empty       level==DEPTH, level==0
module txq_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_100m,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_100m) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: two-source, packet-arbitrated transmit queue feeding uart_tx.
// Ports:
//   clk_100m, rst_n                     clock, asynchronous active-low reset
//   disp_valid/data/last, disp_ready    display source (priority when unlocked)
//   msg_valid/data/last, msg_ready      message source
//   clear                               flush FIFO, release lock, clear overflow
//   tx_data, tx_start, tx_busy          uart_tx handshake
//   level                               FIFO occupancy
//   overflow                            sticky: a source was valid while full
// Optional (macro TXQ_STATS_EN):
//   bytes_sent                          launches since reset/clear (wraps)
//   peak_level                          max level since reset/clear
module uart_tx_queue
  import matrix_calc_pkg::*;
#(
  parameter int DEPTH     = TXQ_DEPTH,
  parameter int AW        = $clog2(DEPTH),
  parameter int BUSY_WAIT = 4
) (
  input  logic          clk_100m,
  input  logic          rst_n,
  input  logic          disp_valid,
  input  logic [7:0]    disp_data,
  input  logic          disp_last,
  output logic          disp_ready,
  input  logic          msg_valid,
  input  logic [7:0]    msg_data,
  input  logic          msg_last,
  output logic          msg_ready,
  input  logic          clear,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic [AW:0]   level,
  output logic          overflow
`ifdef TXQ_STATS_EN
  ,
  output logic [15:0]   bytes_sent,
  output logic [AW:0]   peak_level
`endif
);

  localparam int            CW        = $clog2(BUSY_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(BUSY_WAIT - 1);

  logic       full;
  logic       empty;
  logic [7:0] head;
  logic       lock_valid;
  logic       lock_src;
  logic       disp_fire;
  logic       msg_fire;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic       load_tx;

  txq_state_t    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;

  // Arbiter: ready depends only on registered state and the current valids.
  assign disp_ready = !full && (!lock_valid || lock_src == SRC_DISP);
  assign msg_ready  = !full && (!lock_valid || lock_src == SRC_MSG)
                      && !(!lock_valid && disp_valid);
  assign disp_fire  = disp_valid && disp_ready;
  assign msg_fire   = msg_valid && msg_ready;
  assign push       = (disp_fire || msg_fire) && !clear;
  assign push_data  = disp_fire ? disp_data : msg_data;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid <= 1'b0;
      lock_src   <= SRC_DISP;
    end else if (clear) begin
      lock_valid <= 1'b0;
    end else if (disp_fire) begin
      lock_valid <= !disp_last;
      lock_src   <= SRC_DISP;
    end else if (msg_fire) begin
      lock_valid <= !msg_last;
      lock_src   <= SRC_MSG;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)                           overflow <= 1'b0;
    else if (clear)                       overflow <= 1'b0;
    else if ((disp_valid || msg_valid) && full) overflow <= 1'b1;
  end

  txq_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_100m  (clk_100m),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Drain FSM. tx_data is captured on the IDLE->LAUNCH transition so it is
  // stable for the whole LAUNCH cycle and survives a clear issued then.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      tx_data <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (load_tx) tx_data <= head;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    load_tx = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          state_d = LAUNCH;
          load_tx = 1'b1;
        end
      end
      LAUNCH: begin
        pop     = 1'b1;
        wait_d  = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (tx_busy || wait_q == WAIT_LAST) state_d = WAIT_FALL;
        else                                wait_d  = wait_q + 1'b1;
      end
      WAIT_FALL: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_start = (state_q == LAUNCH);

`ifdef TXQ_STATS_EN
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      bytes_sent <= '0;
      peak_level <= '0;
    end else if (clear) begin
      bytes_sent <= '0;
      peak_level <= '0;
    end else begin
      if (state_q == LAUNCH) bytes_sent <= bytes_sent + 1'b1;
      if (level > peak_level) peak_level <= level;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed, table-driven bench for uart_tx_queue.
module tb_uart_tx_queue;

  logic       clk_100m;
  logic       rst_n;
  logic       disp_valid, disp_last, disp_ready;
  logic [7:0] disp_data;
  logic       msg_valid, msg_last, msg_ready;
  logic [7:0] msg_data;
  logic       clear;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] level;
  logic       overflow;
`ifdef TXQ_STATS_EN
  logic [15:0] bytes_sent;
  logic [4:0]  peak_level;
`endif

  logic auto_busy, man_busy, model_busy;
  int   busy_cnt = 0;
  int   cyc = 0;
  int   bad_start = 0;
  logic [7:0] got[$];
  int   start_cyc[$];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic       dv, dl, mv, ml;
    logic [7:0] dd, md;
    logic       exp_dr, exp_mr;
    logic [4:0] exp_lvl;
  } vec_t;
  vec_t tbl[9];

  initial clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  assign model_busy = (busy_cnt != 0);
  assign tx_busy    = auto_busy ? model_busy : man_busy;

  uart_tx_queue #(
    .DEPTH     (16),
    .BUSY_WAIT (4)
  ) dut (
    .clk_100m   (clk_100m),
    .rst_n      (rst_n),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_last  (disp_last),
    .disp_ready (disp_ready),
    .msg_valid  (msg_valid),
    .msg_data   (msg_data),
    .msg_last   (msg_last),
    .msg_ready  (msg_ready),
    .clear      (clear),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .level      (level),
    .overflow   (overflow)
`ifdef TXQ_STATS_EN
    ,
    .bytes_sent (bytes_sent),
    .peak_level (peak_level)
`endif
  );

  // uart_tx stand-in: busy rises the cycle after tx_start and stays high 10 cycles.
  always @(posedge clk_100m) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      got.push_back(tx_data);
      start_cyc.push_back(cyc);
      if (tx_busy) bad_start <= bad_start + 1;
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int got_at(input int i);
    return (got.size() > i) ? int'(got[i]) : -1;
  endfunction

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic wait_got(input int n, input int limit);
    for (int i = 0; i < limit && got.size() < n; i++) tick();
    chk("launch_count", got.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && (level != 0 || tx_busy); i++) tick();
    chk("drain_idle", int'(level), 0);
    repeat (10) tick();
  endtask

  initial begin
    // dv dl mv ml dd md  dr mr lvl   (tx_busy held high: nothing drains)
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 5'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hA0, 8'hB0, 1'b1, 1'b0, 5'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA1, 8'hB0, 1'b1, 1'b0, 5'd2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hB0, 1'b1, 1'b1, 5'd3};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hA2, 8'hB1, 1'b0, 1'b1, 5'd4};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA2, 8'h00, 1'b0, 1'b1, 5'd4};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 8'hB2, 1'b0, 1'b1, 5'd5};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA2, 8'hB3, 1'b1, 1'b0, 5'd6};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 5'd6};

    rst_n = 1'b0; clear = 1'b0;
    disp_valid = 1'b0; disp_data = '0; disp_last = 1'b0;
    msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0;
    auto_busy = 1'b0; man_busy = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_msg_ready", msg_ready, 1);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);

    // Arbitration table
    for (int i = 0; i < 9; i++) begin
      disp_valid = tbl[i].dv; disp_last = tbl[i].dl; disp_data = tbl[i].dd;
      msg_valid  = tbl[i].mv; msg_last  = tbl[i].ml; msg_data  = tbl[i].md;
      #1;
      chk($sformatf("tbl%0d_disp_ready", i), disp_ready, tbl[i].exp_dr);
      chk($sformatf("tbl%0d_msg_ready", i), msg_ready, tbl[i].exp_mr);
      tick();
      chk($sformatf("tbl%0d_level", i), level, tbl[i].exp_lvl);
    end
    disp_valid = 1'b0; msg_valid = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("tbl_clear_level", level, 0);
    man_busy = 1'b0;
    repeat (5) tick();
    chk("no_launch_after_clear", got.size(), 0);

    // Single byte
    auto_busy = 1'b1;
    disp_valid = 1'b1; disp_data = 8'h41; disp_last = 1'b1;
    tick();
    disp_valid = 1'b0;
    chk("single_level_after_E", level, 1);
    chk("single_no_start_yet", tx_start, 0);
    tick();
    chk("single_tx_start", tx_start, 1);
    chk("single_tx_data", tx_data, 8'h41);
    tick();
    chk("single_start_one_cycle", tx_start, 0);
    wait_idle();
    chk("single_count", got.size(), 1);
    chk("single_byte", got_at(0), 8'h41);

    // Contention: msg packet locks out disp
    got.delete();
    msg_valid = 1'b1; msg_data = 8'h45; msg_last = 1'b0;
    #1 chk("cont_msg_ready0", msg_ready, 1);
    tick();
    msg_data = 8'h52;
    disp_valid = 1'b1; disp_data = 8'h61; disp_last = 1'b1;
    #1 chk("cont_disp_blocked1", disp_ready, 0);
    chk("cont_msg_ready1", msg_ready, 1);
    tick();
    msg_last = 1'b1;
    #1 chk("cont_disp_blocked2", disp_ready, 0);
    tick();
    msg_valid = 1'b0; msg_last = 1'b0;
    #1 chk("cont_disp_released", disp_ready, 1);
    tick();
    disp_valid = 1'b0;
    wait_got(4, 300);
    chk("cont_b0", got_at(0), 8'h45);
    chk("cont_b1", got_at(1), 8'h52);
    chk("cont_b2", got_at(2), 8'h52);
    chk("cont_b3", got_at(3), 8'h61);
    wait_idle();

    // Simultaneous arrival while unlocked
    got.delete();
    disp_valid = 1'b1; disp_data = 8'h31; disp_last = 1'b1;
    msg_valid  = 1'b1; msg_data  = 8'h32; msg_last  = 1'b1;
    #1 chk("simul_disp_ready", disp_ready, 1);
    chk("simul_msg_ready", msg_ready, 0);
    tick();
    disp_valid = 1'b0;
    #1 chk("simul_msg_ready_next", msg_ready, 1);
    tick();
    msg_valid = 1'b0;
    wait_got(2, 300);
    chk("simul_first", got_at(0), 8'h31);
    chk("simul_second", got_at(1), 8'h32);
    wait_idle();

    // Busy timeout: tx_busy stuck low
    auto_busy = 1'b0; man_busy = 1'b0;
    got.delete(); start_cyc.delete();
    disp_valid = 1'b1; disp_data = 8'hA1; disp_last = 1'b1;
    tick();
    disp_data = 8'hA2;
    tick();
    disp_valid = 1'b0;
    wait_got(2, 100);
    chk("timeout_b0", got_at(0), 8'hA1);
    chk("timeout_b1", got_at(1), 8'hA2);
    chk("timeout_spacing", (start_cyc.size() >= 2) ? start_cyc[1] - start_cyc[0] : -1, 7);
    wait_idle();

    // Fill to DEPTH with tx_busy high
    man_busy = 1'b1;
    disp_last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      disp_valid = 1'b1; disp_data = 8'(i);
      tick();
    end
    chk("fill_level", level, 16);
    chk("fill_disp_ready", disp_ready, 0);
    chk("fill_msg_ready", msg_ready, 0);
    chk("fill_no_overflow_yet", overflow, 0);
    tick();
    disp_valid = 1'b0;
    chk("fill_overflow", overflow, 1);
    chk("fill_level_held", level, 16);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("fill_clear_level", level, 0);
    chk("fill_clear_overflow", overflow, 0);
    chk("fill_clear_ready", disp_ready, 1);

    // Reset during WAIT_FALL with 5 bytes queued
    got.delete();
    for (int i = 0; i < 6; i++) begin
      disp_valid = 1'b1; disp_data = 8'h11 + 8'(i);
      tick();
    end
    disp_valid = 1'b0;
    man_busy = 1'b0;
    tick();
    chk("rstmid_launch", tx_start, 1);
    chk("rstmid_data", tx_data, 8'h11);
    tick();
    man_busy = 1'b1;
    tick();
    chk("rstmid_queued", level, 5);
    rst_n = 1'b0;
    tick();
    chk("rstmid_level", level, 0);
    chk("rstmid_tx_start", tx_start, 0);
    chk("rstmid_tx_data", tx_data, 0);
    chk("rstmid_disp_ready", disp_ready, 1);
    chk("rstmid_msg_ready", msg_ready, 1);
    rst_n = 1'b1;
    tick();
    chk("rstmid_after_release", tx_start, 0);

    chk("start_while_busy", bad_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
